muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised RV32M/RV64M execute-stage unit implementing MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the ALU in the EX stage. The pipeline controller issues an op with a one-cycle start pulse and stalls IF/ID/EX while busy_o is high.
- The result returns with a one-cycle done pulse plus the destination register address for the EX/MEM latch.
- Multiply uses a configurable pipelined latency. Divide is an iterative radix-2 restoring divider with single-cycle fast paths for RISC-V special cases.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- MUL_LAT, 1, multiply latency in cycles, 1..4. Extra cycles are a register shift of the product.
- REG_ADDR_W, 5, destination register address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  issue pulse; sampled on rising edge
- op_i  in  3  funct3 of the M-extension instruction (000 MUL … 111 REMU)
- rs1_i  in  XLEN  operand A (already forwarded)
- rs2_i  in  XLEN  operand B (already forwarded)
- rd_i  in  REG_ADDR_W  destination register
- flush_i  in  1  kill in-flight op (branch mispredict/trap)
- busy_o  out  1  op in flight; pipeline must stall
- done_o  out  1  one-cycle pulse; result_o/rd_o valid
- result_o  out  XLEN  result; holds last value until next done
- rd_o  out  REG_ADDR_W  destination of completed op

Behaviour:
- **Clock and reset:** one clock (clk); reset (rst) is synchronous and active-high.
  - On rst: state=IDLE; busy_o=0, done_o=0, result_o=0, rd_o=0; all internal counters and operands cleared.
  - rst mid-operation aborts the op with no done pulse.
- **States:** IDLE, MUL, DIV, FIX, DONE. busy_o = (state==MUL|DIV|FIX). done_o = (state==DONE).
- **Accept:** start_i is accepted only in IDLE or DONE; start_i in other states is ignored. This allows back-to-back ops, with a new start accepted in the DONE cycle. On accept, operands, op and rd are latched. Let T be the accepting edge.
- **Multiply:**
  - Product width 2*XLEN. Signedness: MULH s×s, MULHSU s×u, MULHU u×u.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
  - State MUL lasts MUL_LAT-1 cycles (skipped when MUL_LAT=1). done_o is high in cycle T+MUL_LAT.
- **Divide, special cases** (go directly to DONE; done_o at T+1):
  - rs2==0: DIV/DIVU quotient = all ones; REM/REMU = rs1.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1, DIV/REM only): quotient = rs1; remainder = 0.
- **Divide, normal:**
  - Operands are converted to magnitudes (signed ops); the result signs are recorded (quotient sign = sA^sB, remainder sign = sA).
  - DIV state runs XLEN iterations with a counter 0..XLEN-1, one quotient bit per cycle.
  - FIX state applies sign correction for one cycle. done_o is high at T+XLEN+2 (34 for XLEN=32).
- **Rounding:** truncating toward zero; the remainder has the sign of the dividend (RISC-V semantics).
- **Flush:** flush_i in any state returns to IDLE on the next edge; done_o is not asserted and result_o/rd_o are unchanged.
  - flush_i together with start_i: flush wins and the start is dropped.
  - flush_i in the DONE cycle: done_o stays high that cycle (already committed); the next state is IDLE.
- **Outputs:** result_o and rd_o are registered and update only on entry to DONE.

Decomposition:
- **Package muldiv_pkg** contains:
  - typedef enum muldiv_op_e (MUL=3'b000, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU);
  - typedef enum state_e;
  - helper function is_div(op).
- **Sub-module muldiv_div_core:** the iterative restoring divider.
  - Inputs: clk, rst, load, dividend magnitude, divisor magnitude, step enable.
  - Outputs: quotient and remainder magnitudes, last_iter flag.
  - The top holds the FSM, sign logic, special-case detection and multiply path.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD), MUL_LAT=1 → done at T+1, result 0xFFFFFFEB; MULH same operands → 0xFFFFFFFF; MULHU → 0x00000006; MULHSU rs1=-1, rs2=2 → 0xFFFFFFFF.
- DIV rs1=-20, rs2=6 → done at T+34, result 0xFFFFFFFD (-3), busy_o high T+1..T+33; REM same operands → 0xFFFFFFFE (-2); DIVU 100/7 → 14, REMU → 2.
- Divide by zero: DIVU 0x1234/0 → 0xFFFFFFFF at T+1; REM 0x1234/0 → 0x1234; overflow DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- Flush at T+10 during DIV rd=5 → IDLE at T+11, no done pulse, result_o/rd_o keep prior values; start_i+flush_i same cycle → no accept.
- Back-to-back: MUL (rd=3) then start DIVU in its DONE cycle → first done with rd_o=3, second op accepted with no idle gap; start_i pulses while busy are ignored.
- MUL_LAT=3 rebuild: MUL 0x10000×0x10000 → done at T+3, result 0, MULHU → 1; rst asserted mid-DIV → all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes, one quotient bit per step.
module muldiv_div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            step_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o,
  output logic            last_iter_o
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   shifted, trial;

  // The quotient register doubles as the dividend shift register.
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
      cnt_d = '0;
    end else if (step_i) begin
      if (!trial[XLEN]) begin
        rem_d = trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quo_o       = quo_q;
  assign rem_o       = rem_q;
  assign last_iter_o = (cnt_q == CW'(XLEN - 1));

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage M-extension unit: pipelined multiply, iterative divide with special-case fast paths.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_LAT    = 1,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       rs1_i,
  input  logic [XLEN-1:0]       rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [XLEN-1:0]       result_o,
  output logic [REG_ADDR_W-1:0] rd_o
);

  localparam int unsigned PW       = 2 * XLEN;
  localparam int unsigned PIPE_D   = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam int unsigned MUL_LAST = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
  localparam int unsigned MCW      = 2;

  state_e                state_q, state_d;
  muldiv_op_e            op_c;
  logic                  accept_c;
  logic [PW-1:0]         a_ext_c, b_ext_c, prod_c;
  logic [XLEN-1:0]       mul_res_c, spec_res_c, issue_res_c, fix_res_c;
  logic [XLEN-1:0]       a_mag_c, b_mag_c, quo, rem;
  logic                  sa_c, sb_c, div_signed_c, a_neg_c, b_neg_c;
  logic                  div0_c, ovf_c, special_c, last_iter;
  logic [XLEN-1:0]       mul_pipe_q [PIPE_D];
  logic [MCW-1:0]        mul_cnt_q;
  logic [REG_ADDR_W-1:0] rd_q, rd_out_q;
  logic                  is_rem_q, q_neg_q, r_neg_q;
  logic [XLEN-1:0]       result_q;

  assign op_c     = muldiv_op_e'(op_i);
  assign accept_c = start_i && !flush_i && (state_q == S_IDLE || state_q == S_DONE);

  // Multiply operands are sign- or zero-extended so one 2*XLEN multiply serves all four ops.
  always_comb begin
    sa_c      = (op_c == MULH || op_c == MULHSU) && rs1_i[XLEN-1];
    sb_c      = (op_c == MULH) && rs2_i[XLEN-1];
    a_ext_c   = {{XLEN{sa_c}}, rs1_i};
    b_ext_c   = {{XLEN{sb_c}}, rs2_i};
    prod_c    = a_ext_c * b_ext_c;
    mul_res_c = (op_c == MUL) ? prod_c[XLEN-1:0] : prod_c[PW-1:XLEN];
  end

  // Divide operand conditioning and the results that bypass the iterative core.
  always_comb begin
    div_signed_c = !op_i[0];
    a_neg_c      = div_signed_c && rs1_i[XLEN-1];
    b_neg_c      = div_signed_c && rs2_i[XLEN-1];
    a_mag_c      = a_neg_c ? -rs1_i : rs1_i;
    b_mag_c      = b_neg_c ? -rs2_i : rs2_i;
    div0_c       = (rs2_i == '0);
    ovf_c        = div_signed_c && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    special_c    = div0_c || ovf_c;
    if (div0_c) spec_res_c = op_i[1] ? rs1_i : '1;
    else        spec_res_c = op_i[1] ? '0 : rs1_i;
    issue_res_c  = is_div(op_c) ? spec_res_c : mul_res_c;
    if (is_rem_q) fix_res_c = r_neg_q ? -rem : rem;
    else          fix_res_c = q_neg_q ? -quo : quo;
  end

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept_c && is_div(op_c)),
    .dividend_i  (a_mag_c),
    .divisor_i   (b_mag_c),
    .step_i      (state_q == S_DIV),
    .quo_o       (quo),
    .rem_o       (rem),
    .last_iter_o (last_iter)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            if (is_div(op_c)) state_d = special_c ? S_DONE : S_DIV;
            else              state_d = (MUL_LAT > 1) ? S_MUL : S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL:   if (mul_cnt_q == MCW'(MUL_LAST)) state_d = S_DONE;
        S_DIV:   if (last_iter) state_d = S_FIX;
        S_FIX:   state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    done_o = (state_q == S_DONE);
  end

  // Datapath registers; result/rd only change on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PIPE_D); i++) mul_pipe_q[i] <= '0;
      mul_cnt_q <= '0;
      rd_q      <= '0;
      is_rem_q  <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      mul_pipe_q[0] <= mul_res_c;
      for (int i = 1; i < int'(PIPE_D); i++) mul_pipe_q[i] <= mul_pipe_q[i-1];
      if (accept_c)              mul_cnt_q <= '0;
      else if (state_q == S_MUL) mul_cnt_q <= mul_cnt_q + 1'b1;
      if (accept_c) begin
        rd_q     <= rd_i;
        is_rem_q <= op_i[1];
        q_neg_q  <= a_neg_c ^ b_neg_c;
        r_neg_q  <= a_neg_c;
      end
      if (state_d == S_DONE) begin
        case (state_q)
          S_MUL: begin
            result_q <= mul_pipe_q[PIPE_D-1];
            rd_out_q <= rd_q;
          end
          S_FIX: begin
            result_q <= fix_res_c;
            rd_out_q <= rd_q;
          end
          default: begin
            result_q <= issue_res_c;
            rd_out_q <= rd_i;
          end
        endcase
      end
    end
  end

  assign result_o = result_q;
  assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table on a MUL_LAT=1 instance, hand sequences, MUL_LAT=3 instance.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int NV = 15;

  logic        clk = 1'b0;
  logic        rst, rst3, start, start3, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        busy, done, busy3, done3;
  logic [31:0] result, result3;
  logic [4:0]  rd_out, rd_out3;

  int cyc = 0;
  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    muldiv_op_e  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt [NV];

  muldiv_unit #(.XLEN(32), .MUL_LAT(1), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .rd_i(rd), .flush_i(flush), .busy_o(busy), .done_o(done), .result_o(result), .rd_o(rd_out)
  );

  muldiv_unit #(.XLEN(32), .MUL_LAT(3), .REG_ADDR_W(5)) dut3 (
    .clk(clk), .rst(rst3), .start_i(start3), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .rd_i(rd), .flush_i(1'b0), .busy_o(busy3), .done_o(done3), .result_o(result3), .rd_o(rd_out3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a one-cycle start; returns in cycle T+1 with t0 marking it.
  task automatic issue(input bit sel, input muldiv_op_e o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, output int t0);
    op = o; rs1 = a; rs2 = b; rd = d;
    if (sel) start3 = 1'b1;
    else     start  = 1'b1;
    @(negedge clk);
    start = 1'b0; start3 = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input bit sel, output bit seen, output int drops);
    seen = 1'b0; drops = 0;
    for (int k = 0; k < 100; k++) begin
      if (sel ? done3 : done) begin
        seen = 1'b1;
        break;
      end
      if (!(sel ? busy3 : busy)) drops++;
      @(negedge clk);
    end
  endtask

  initial begin
    int  t0, t1, drops, lat;
    bit  seen, any_done;
    logic [31:0] prior_res;
    logic [4:0]  prior_rd;

    vt[0]  = '{MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1};
    vt[1]  = '{MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 1};
    vt[2]  = '{MULHU,  32'd7,        32'hFFFFFFFD, 32'h00000006, 1};
    vt[3]  = '{MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1};
    vt[4]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1};
    vt[5]  = '{DIV,    32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 34};
    vt[6]  = '{REM,    32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 34};
    vt[7]  = '{DIVU,   32'd100,      32'd7,        32'd14,       34};
    vt[8]  = '{REMU,   32'd100,      32'd7,        32'd2,        34};
    vt[9]  = '{DIV,    32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, 34};
    vt[10] = '{REM,    32'd20,       32'hFFFFFFFA, 32'd2,        34};
    vt[11] = '{DIV,    32'h80000000, 32'd2,        32'hC0000000, 34};
    vt[12] = '{DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF, 1};
    vt[13] = '{REM,    32'h1234,     32'd0,        32'h1234,     1};
    vt[14] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};

    rst = 1'b1; rst3 = 1'b1; start = 1'b0; start3 = 1'b0; flush = 1'b0;
    op = 3'd0; rs1 = '0; rs2 = '0; rd = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset rd", 64'(rd_out), 64'd0);
    check("reset3 result", 64'(result3), 64'd0);
    rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      issue(1'b0, vt[i].op, vt[i].a, vt[i].b, 5'(i + 1), t0);
      wait_done(1'b0, seen, drops);
      lat = cyc - t0 + 1;
      check($sformatf("v%0d done seen", i), 64'(seen), 64'd1);
      check($sformatf("v%0d latency", i), 64'(lat), 64'(vt[i].lat));
      check($sformatf("v%0d result", i), 64'(result), 64'(vt[i].exp));
      check($sformatf("v%0d rd", i), 64'(rd_out), 64'(i + 1));
      if (vt[i].lat > 1) check($sformatf("v%0d busy gaps", i), 64'(drops), 64'd0);
      @(negedge clk);
    end
    prior_res = vt[NV-1].exp;
    prior_rd  = 5'(NV);

    // Flush mid-divide: no done pulse, outputs unchanged.
    issue(1'b0, DIV, 32'hFFFFFFEC, 32'd6, 5'd5, t0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    any_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) any_done = 1'b1;
      @(negedge clk);
    end
    check("flush no done", 64'(any_done), 64'd0);
    check("flush result kept", 64'(result), 64'(prior_res));
    check("flush rd kept", 64'(rd_out), 64'(prior_rd));

    // start together with flush is dropped.
    op = MUL; rs1 = 32'd2; rs2 = 32'd3; rd = 5'd7; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start+flush done", 64'(done), 64'd0);
    check("start+flush busy", 64'(busy), 64'd0);
    check("start+flush result", 64'(result), 64'(prior_res));

    // Back-to-back: start DIVU in the MUL's DONE cycle; a pulse while busy is ignored.
    @(negedge clk);
    issue(1'b0, MUL, 32'd2, 32'd3, 5'd3, t0);
    check("b2b mul done", 64'(done), 64'd1);
    check("b2b mul rd", 64'(rd_out), 64'd3);
    check("b2b mul result", 64'(result), 64'd6);
    issue(1'b0, DIVU, 32'd100, 32'd7, 5'd4, t1);
    check("b2b div busy", 64'(busy), 64'd1);
    check("b2b div no done", 64'(done), 64'd0);
    issue(1'b0, MUL, 32'd5, 32'd5, 5'd9, t0);
    wait_done(1'b0, seen, drops);
    check("b2b div seen", 64'(seen), 64'd1);
    check("b2b div latency", 64'(cyc - t1 + 1), 64'd34);
    check("b2b div result", 64'(result), 64'd14);
    check("b2b div rd", 64'(rd_out), 64'd4);
    @(negedge clk);
    check("b2b ignored start", 64'({busy, done}), 64'd0);

    // MUL_LAT=3 instance.
    issue(1'b1, MUL, 32'h10000, 32'h10000, 5'd6, t0);
    check("lat3 busy", 64'(busy3), 64'd1);
    wait_done(1'b1, seen, drops);
    check("lat3 mul latency", 64'(cyc - t0 + 1), 64'd3);
    check("lat3 mul result", 64'(result3), 64'd0);
    check("lat3 mul rd", 64'(rd_out3), 64'd6);
    @(negedge clk);
    issue(1'b1, MULHU, 32'h10000, 32'h10000, 5'd2, t0);
    wait_done(1'b1, seen, drops);
    check("lat3 mulhu latency", 64'(cyc - t0 + 1), 64'd3);
    check("lat3 mulhu result", 64'(result3), 64'd1);
    @(negedge clk);

    // Reset in the middle of a divide clears everything.
    issue(1'b1, DIV, 32'hFFFFFFEC, 32'd6, 5'd8, t0);
    repeat (5) @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    check("midrst outputs", 64'({busy3, done3, result3, rd_out3}), 64'd0);
    any_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done3) any_done = 1'b1;
      @(negedge clk);
    end
    check("midrst no done", 64'(any_done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
